// File: rtl/pacman_display_timing.sv
`default_nettype none
// ============================================================================
// pacman_display_timing : VGA raster timing with letterboxed, upscaled
// 224x288 game coordinates. Optional macro PACMAN_TIMING_FRAME_COUNT_EN adds
// the 16-bit frame_cnt output.                                  Rev 1.0
// ============================================================================
module pacman_display_timing #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter int SYNC_POS = 1,
   parameter int GAME_W   = 224,
   parameter int GAME_H   = 288,
   parameter int SCALE    = 2
) (
   input  logic                      vga_pix_clk,
   input  logic                      rst,
   output logic                      hsync,
   output logic                      vsync,
   output logic                      vga_de,
   output logic [$clog2(GAME_W)-1:0] sx,
   output logic [$clog2(GAME_H)-1:0] sy,
   output logic                      display_enabled,
   output logic                      game_pix_stb,
   output logic                      frame_stb,
   output logic                      vblank_stb
`ifdef PACMAN_TIMING_FRAME_COUNT_EN
   ,
   output logic [15:0]               frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_OFF   = (H_ACTIVE - SCALE * GAME_W) / 2;
   localparam int V_OFF   = (V_ACTIVE - SCALE * GAME_H) / 2;

   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int XW = $clog2(GAME_W);
   localparam int YW = $clog2(GAME_H);
   localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_WIN_LO  = HW'(H_OFF);
   localparam logic [HW-1:0] H_WIN_HI  = HW'(H_OFF + SCALE * GAME_W);
   localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_WIN_LO  = VW'(V_OFF);
   localparam logic [VW-1:0] V_WIN_HI  = VW'(V_OFF + SCALE * GAME_H);
   localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SW-1:0] SUB_LAST  = SW'(SCALE - 1);
   localparam logic [XW-1:0] GX_LAST   = XW'(GAME_W - 1);
   localparam logic [YW-1:0] GY_LAST   = YW'(GAME_H - 1);
   localparam logic          SYNC_ON   = (SYNC_POS != 0);

   if (SCALE * GAME_W > H_ACTIVE) begin : g_bad_width
      $error("pacman_display_timing: SCALE*GAME_W exceeds H_ACTIVE");
   end
   if (SCALE * GAME_H > V_ACTIVE) begin : g_bad_height
      $error("pacman_display_timing: SCALE*GAME_H exceeds V_ACTIVE");
   end

   logic [HW-1:0] hc;
   logic [VW-1:0] vc;
   logic [SW-1:0] hsub;
   logic [SW-1:0] vsub;
   logic [XW-1:0] gx;
   logic [YW-1:0] gy;

   logic h_win, v_win, de_nxt, line_end, frame_end;
   logic hs_act, vs_act, pix_nxt, frame_nxt;

   assign h_win     = (hc >= H_WIN_LO) && (hc < H_WIN_HI);
   assign v_win     = (vc >= V_WIN_LO) && (vc < V_WIN_HI);
   assign de_nxt    = h_win && v_win;
   assign line_end  = (hc == H_LAST);
   assign frame_end = line_end && (vc == V_LAST);
   assign hs_act    = (hc >= H_SYNC_LO) && (hc < H_SYNC_HI);
   assign vs_act    = (vc >= V_SYNC_LO) && (vc < V_SYNC_HI);
   assign pix_nxt   = de_nxt && (hsub == '0) && (vsub == '0);
   assign frame_nxt = pix_nxt && (gx == '0) && (gy == '0);

   // Sub-pixel counters only move inside their window; gx/gy saturate so the
   // trailing wrap of the last game pixel never overflows the coordinate.
   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         hc   <= '0;
         vc   <= '0;
         hsub <= '0;
         vsub <= '0;
         gx   <= '0;
         gy   <= '0;
      end else if (line_end) begin
         hc   <= '0;
         hsub <= '0;
         gx   <= '0;
         if (frame_end) begin
            vc   <= '0;
            vsub <= '0;
            gy   <= '0;
         end else begin
            vc <= vc + VW'(1);
            if (v_win) begin
               if (vsub == SUB_LAST) begin
                  vsub <= '0;
                  if (gy != GY_LAST) gy <= gy + YW'(1);
               end else begin
                  vsub <= vsub + SW'(1);
               end
            end
         end
      end else begin
         hc <= hc + HW'(1);
         if (h_win) begin
            if (hsub == SUB_LAST) begin
               hsub <= '0;
               if (gx != GX_LAST) gx <= gx + XW'(1);
            end else begin
               hsub <= hsub + SW'(1);
            end
         end
      end
   end

   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         hsync           <= ~SYNC_ON;
         vsync           <= ~SYNC_ON;
         vga_de          <= 1'b0;
         sx              <= '0;
         sy              <= '0;
         display_enabled <= 1'b0;
         game_pix_stb    <= 1'b0;
         frame_stb       <= 1'b0;
         vblank_stb      <= 1'b0;
      end else begin
         hsync           <= hs_act ? SYNC_ON : ~SYNC_ON;
         vsync           <= vs_act ? SYNC_ON : ~SYNC_ON;
         vga_de          <= (hc < H_ACT) && (vc < V_ACT);
         sx              <= h_win ? gx : '0;
         sy              <= v_win ? gy : '0;
         display_enabled <= de_nxt;
         game_pix_stb    <= pix_nxt;
         frame_stb       <= frame_nxt;
         vblank_stb      <= (hc == '0) && (vc == V_ACT);
      end
   end

`ifdef PACMAN_TIMING_FRAME_COUNT_EN
   always_ff @(posedge vga_pix_clk) begin
      if (rst) frame_cnt <= '0;
      else if (frame_nxt) frame_cnt <= frame_cnt + 16'd1;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pacman_display_timing.sv
`default_nettype none
// Bench for pacman_display_timing: two reduced-size rasters (SCALE=2 active-high
// syncs, SCALE=1 active-low syncs) checked cycle by cycle against a raster model.
module tb_pacman_display_timing;

   // per config: H_ACTIVE,H_FP,H_SYNC,H_BP,V_ACTIVE,V_FP,V_SYNC,V_BP,GAME_W,GAME_H,SCALE,SYNC_POS
   localparam int P0 [12] = '{20, 2, 3, 3, 16, 1, 2, 2, 8, 6, 2, 1};
   localparam int P1 [12] = '{12, 1, 2, 2, 10, 1, 1, 2, 8, 6, 1, 0};
   localparam int FRAME0 = (20 + 2 + 3 + 3) * (16 + 1 + 2 + 2);

   typedef struct packed {
      logic hs, vs, vde, de, gps, frm, vb;
      logic [15:0] x, y;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic hsync0, vsync0, vga_de0, de0, gps0, frm0, vb0;
   logic hsync1, vsync1, vga_de1, de1, gps1, frm1, vb1;
   logic [2:0] sx0, sy0, sx1, sy1;
`ifdef PACMAN_TIMING_FRAME_COUNT_EN
   logic [15:0] frame_cnt0, frame_cnt1;
`endif

   pacman_display_timing #(
      .H_ACTIVE(P0[0]), .H_FP(P0[1]), .H_SYNC(P0[2]), .H_BP(P0[3]),
      .V_ACTIVE(P0[4]), .V_FP(P0[5]), .V_SYNC(P0[6]), .V_BP(P0[7]),
      .GAME_W(P0[8]), .GAME_H(P0[9]), .SCALE(P0[10]), .SYNC_POS(P0[11])
   ) dut0 (
      .vga_pix_clk(clk), .rst(rst), .hsync(hsync0), .vsync(vsync0),
      .vga_de(vga_de0), .sx(sx0), .sy(sy0), .display_enabled(de0),
      .game_pix_stb(gps0), .frame_stb(frm0), .vblank_stb(vb0)
`ifdef PACMAN_TIMING_FRAME_COUNT_EN
      , .frame_cnt(frame_cnt0)
`endif
   );

   pacman_display_timing #(
      .H_ACTIVE(P1[0]), .H_FP(P1[1]), .H_SYNC(P1[2]), .H_BP(P1[3]),
      .V_ACTIVE(P1[4]), .V_FP(P1[5]), .V_SYNC(P1[6]), .V_BP(P1[7]),
      .GAME_W(P1[8]), .GAME_H(P1[9]), .SCALE(P1[10]), .SYNC_POS(P1[11])
   ) dut1 (
      .vga_pix_clk(clk), .rst(rst), .hsync(hsync1), .vsync(vsync1),
      .vga_de(vga_de1), .sx(sx1), .sy(sy1), .display_enabled(de1),
      .game_pix_stb(gps1), .frame_stb(frm1), .vblank_stb(vb1)
`ifdef PACMAN_TIMING_FRAME_COUNT_EN
      , .frame_cnt(frame_cnt1)
`endif
   );

   out_t q0[$];
   out_t q1[$];
   int   total = 0;
   int   passed = 0;
   int   fails = 0;
   int   cyc = 0;
   int   mh[2], mv[2], restart[2], last_frm[2], nfrm[2];
   int   c_vde[2], c_de[2], c_gps[2], c_frm[2], c_co[2];
   bit   pend[2], started[2], have_frm[2];

   function automatic int p(input int c, input int k);
      return (c == 0) ? P0[k] : P1[k];
   endfunction
   function automatic int htot(input int c);
      return p(c, 0) + p(c, 1) + p(c, 2) + p(c, 3);
   endfunction
   function automatic int vtot(input int c);
      return p(c, 4) + p(c, 5) + p(c, 6) + p(c, 7);
   endfunction
   function automatic int hoff(input int c);
      return (p(c, 0) - p(c, 10) * p(c, 8)) / 2;
   endfunction
   function automatic int voff(input int c);
      return (p(c, 4) - p(c, 10) * p(c, 9)) / 2;
   endfunction

   function automatic out_t reset_val(input int c);
      out_t o = '0;
      o.hs = (p(c, 11) == 0);
      o.vs = (p(c, 11) == 0);
      return o;
   endfunction

   function automatic out_t model(input int c, input int hc, input int vc);
      out_t o  = '0;
      int   s  = p(c, 10);
      int   ho = hoff(c);
      int   vo = voff(c);
      int   hs0 = p(c, 0) + p(c, 1);
      int   vs0 = p(c, 4) + p(c, 5);
      logic on = (p(c, 11) != 0);
      logic hw = (hc >= ho) && (hc < ho + s * p(c, 8));
      logic vw = (vc >= vo) && (vc < vo + s * p(c, 9));
      o.hs  = (hc >= hs0 && hc < hs0 + p(c, 2)) ? on : !on;
      o.vs  = (vc >= vs0 && vc < vs0 + p(c, 6)) ? on : !on;
      o.vde = (hc < p(c, 0)) && (vc < p(c, 4));
      o.de  = hw && vw;
      o.x   = hw ? 16'((hc - ho) / s) : 16'd0;
      o.y   = vw ? 16'((vc - vo) / s) : 16'd0;
      o.gps = o.de && ((hc - ho) % s == 0) && ((vc - vo) % s == 0);
      o.frm = o.de && (hc == ho) && (vc == vo);
      o.vb  = (hc == 0) && (vc == p(c, 4));
      return o;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, expv);
      end
   endtask

   task automatic advance(input int c, input bit r);
      if (r) begin
         mh[c] = 0;
         mv[c] = 0;
      end else begin
         mh[c]++;
         if (mh[c] == htot(c)) begin
            mh[c] = 0;
            mv[c]++;
            if (mv[c] == vtot(c)) mv[c] = 0;
         end
      end
   endtask

   task automatic stats(input int i, input out_t g, input bit wr);
      if (wr) begin
         started[i] = 0; have_frm[i] = 0; pend[i] = 1; restart[i] = -1; nfrm[i] = 0;
         return;
      end
      restart[i]++;
      if (g.vb) begin
         if (started[i]) begin
            chk($sformatf("vga_de_count%0d", i), 64'(c_vde[i]), 64'(p(i, 0) * p(i, 4)));
            chk($sformatf("de_count%0d", i), 64'(c_de[i]),
                64'(p(i, 10) * p(i, 10) * p(i, 8) * p(i, 9)));
            chk($sformatf("pix_stb_count%0d", i), 64'(c_gps[i]), 64'(p(i, 8) * p(i, 9)));
            chk($sformatf("frame_stb_count%0d", i), 64'(c_frm[i]), 64'd1);
            chk($sformatf("vblank_frame_overlap%0d", i), 64'(c_co[i]), 64'd0);
         end
         started[i] = 1;
         c_vde[i] = 0; c_de[i] = 0; c_gps[i] = 0; c_frm[i] = 0; c_co[i] = 0;
      end
      c_vde[i] += int'(g.vde);
      c_de[i]  += int'(g.de);
      c_gps[i] += int'(g.gps);
      c_frm[i] += int'(g.frm);
      c_co[i]  += int'(g.frm && g.vb);
      if (g.frm) begin
         nfrm[i]++;
         if (pend[i]) begin
            chk($sformatf("restart_latency%0d", i), 64'(restart[i]),
                64'(voff(i) * htot(i) + hoff(i)));
            pend[i] = 0;
         end
         if (have_frm[i])
            chk($sformatf("frame_period%0d", i), 64'(cyc - last_frm[i]),
                64'(htot(i) * vtot(i)));
         last_frm[i] = cyc;
         have_frm[i] = 1;
`ifdef PACMAN_TIMING_FRAME_COUNT_EN
         chk($sformatf("frame_cnt%0d", i),
             64'((i == 0) ? frame_cnt0 : frame_cnt1), 64'(nfrm[i] & 16'hFFFF));
`endif
      end
   endtask

   // Expected outputs are queued at the edge that samples the raster position
   // and compared one cycle later, when the registered outputs appear.
   task automatic cycle();
      out_t g0, g1, e0, e1;
      bit   wr = rst;
      q0.push_back(wr ? reset_val(0) : model(0, mh[0], mv[0]));
      q1.push_back(wr ? reset_val(1) : model(1, mh[1], mv[1]));
      advance(0, wr);
      advance(1, wr);
      @(posedge clk);
      #1;
      cyc++;
      g0 = {hsync0, vsync0, vga_de0, de0, gps0, frm0, vb0, 16'(sx0), 16'(sy0)};
      g1 = {hsync1, vsync1, vga_de1, de1, gps1, frm1, vb1, 16'(sx1), 16'(sy1)};
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      chk("dut0_outputs", 64'(g0), 64'(e0));
      chk("dut1_outputs", 64'(g1), 64'(e1));
      stats(0, g0, wr);
      stats(1, g1, wr);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         mh[i] = 0; mv[i] = 0; restart[i] = -1; last_frm[i] = 0; nfrm[i] = 0;
         pend[i] = 0; started[i] = 0; have_frm[i] = 0;
         c_vde[i] = 0; c_de[i] = 0; c_gps[i] = 0; c_frm[i] = 0; c_co[i] = 0;
      end
      rst = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;
      repeat (2 * FRAME0 + 40) cycle();
      for (int k = 0; k < FRAME0 && mv[0] != vtot(0) / 2; k++) cycle();
      rst = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;
      repeat (2 * FRAME0 + 40) cycle();
      chk("restart_frame_seen0", 64'(pend[0]), 64'd0);
      chk("restart_frame_seen1", 64'(pend[1]), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
